// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI shift unit: FSM state encoding, endian codes,
// effective frame length and the L-bit alignment/reversal used by both TX and RX paths.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_DELIVER = 2'd2
    } shift_state_e;

    localparam logic ENDIAN_MSB = 1'b0;
    localparam logic ENDIAN_LSB = 1'b1;

    // Helpers work on a fixed 32-bit container, so WIDTH is limited to 32.
    localparam int MAX_WIDTH = 32;
    localparam int LEN_W     = 6;
    localparam int IDX_W     = 5;

    function automatic logic [LEN_W-1:0] eff_len(input logic [3:0] frame_len, input int width);
        int len;
        len = int'(frame_len);
        if (len == 0 || len > width) begin
            len = width;
        end
        return LEN_W'(len);
    endfunction

    // Keeps the low len bits of v (optionally reversed across those len bits); upper bits zero.
    function automatic logic [MAX_WIDTH-1:0] low_bits(input logic [MAX_WIDTH-1:0] v,
                                                      input logic [LEN_W-1:0]     len,
                                                      input logic                 reverse);
        logic [MAX_WIDTH-1:0] r;
        logic [IDX_W-1:0]     idx;
        int                   n;
        r = '0;
        n = int'(len);
        for (int i = 0; i < MAX_WIDTH; i++) begin
            idx = IDX_W'(n - 1 - i);
            if (i < n) begin
                r[i] = reverse ? v[idx] : v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_rx_packer.sv
// Receive side of the SPI shift unit: collects sampled bits, aligns the finished frame
// to the low L bits (reversed for LSB-first) and pushes it or flags an overrun.
module spi_rx_packer
    import spi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             clear_i,
    input  logic             sample_i,
    input  logic             rx_bit_i,
    input  logic             capture_i,
    input  logic             deliver_i,
    input  logic [LEN_W-1:0] frame_len_i,
    input  logic             endian_i,
    input  logic             rx_fifo_full_i,
    input  logic             overrun_clear_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_write_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] rx_shift_q;
    logic [WIDTH-1:0] rx_shift_d;
    logic [WIDTH-1:0] rx_data_q;
    logic [WIDTH-1:0] rx_aligned;
    logic             overrun_q;
    logic             overrun_set;

    // NOTE: default assignment first keeps this always_comb free of inferred latches.
    always_comb begin
        rx_shift_d = rx_shift_q;
        if (clear_i) begin
            rx_shift_d = '0;
        end else if (sample_i) begin
            rx_shift_d = {rx_shift_q[WIDTH-2:0], rx_bit_i};
        end
    end

    assign rx_aligned  = WIDTH'(low_bits(MAX_WIDTH'(rx_shift_d), frame_len_i, endian_i == ENDIAN_LSB));
    assign overrun_set = deliver_i && rx_fifo_full_i;

    // NOTE: non-blocking assignments so every flop sees pre-edge values regardless of block order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            rx_shift_q <= rx_shift_d;
            if (capture_i) begin
                rx_data_q <= rx_aligned;
            end
            // A dropped frame must stay visible even if software clears in the same cycle.
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (overrun_clear_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_write_o = deliver_i && !rx_fifo_full_i;
    assign overrun_o  = overrun_q;

endmodule

// File: rtl/spi_shift_unit.sv
// SPI shift unit: pops TX FIFO frames, serialises them on SPIOut and packs SPIIn into RX words.
// Define SPI_LOOPBACK_EN to add the Loopback input (SampleEdge then captures SPIOut).
module spi_shift_unit
    import spi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             TransmitStart,
    input  logic             ShiftEdge,
    input  logic             SampleEdge,
    input  logic             EndOfFrameDelay,
    input  logic [3:0]       FrameLength,
    input  logic             Endian,
    input  logic [WIDTH-1:0] TxData,
    input  logic             TxFIFOReadEmpty,
    output logic             TxFIFORead,
    input  logic             SPIIn,
    output logic             SPIOut,
    input  logic             RxFIFOFull,
    output logic [WIDTH-1:0] RxData,
    output logic             RxWrite,
`ifdef SPI_LOOPBACK_EN
    input  logic             Loopback,
`endif
    input  logic             RxOverrunClear,
    output logic             RxOverrun
);

    shift_state_e     state_q;
    logic [WIDTH-1:0] tx_shift_q;
    logic             spi_out_q;
    logic             tx_read_q;
    logic [LEN_W-1:0] frame_len;
    logic [WIDTH-1:0] tx_load;
    logic [WIDTH-1:0] tx_next;
    logic             load_frame;
    logic             rx_bit;

    assign frame_len = eff_len(FrameLength, WIDTH);

    // Left-justified so the first frame bit always leaves from the MSB.
    assign tx_load = WIDTH'(low_bits(MAX_WIDTH'(TxData), frame_len, Endian == ENDIAN_LSB))
                     << (WIDTH - int'(frame_len));
    assign tx_next = {tx_shift_q[WIDTH-2:0], 1'b0};

    assign load_frame = !TxFIFOReadEmpty &&
                        ((state_q == ST_IDLE && TransmitStart) || state_q == ST_DELIVER);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= ST_IDLE;
            tx_shift_q <= '0;
            spi_out_q  <= 1'b0;
            tx_read_q  <= 1'b0;
        end else begin
            tx_read_q <= 1'b0;
            if (load_frame) begin
                state_q    <= ST_SHIFT;
                tx_shift_q <= tx_load;
                spi_out_q  <= tx_load[WIDTH-1];
                tx_read_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        spi_out_q <= 1'b0;
                    end
                    ST_SHIFT: begin
                        // End of frame wins over a coincident shift strobe.
                        if (EndOfFrameDelay) begin
                            state_q <= ST_DELIVER;
                        end else if (ShiftEdge) begin
                            tx_shift_q <= tx_next;
                            spi_out_q  <= tx_next[WIDTH-1];
                        end
                    end
                    ST_DELIVER: begin
                        state_q   <= ST_IDLE;
                        spi_out_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = Loopback ? spi_out_q : SPIIn;
`else
    assign rx_bit = SPIIn;
`endif

    spi_rx_packer #(
        .WIDTH(WIDTH)
    ) u_rx_packer (
        .PCLK           (PCLK),
        .PRESETn        (PRESETn),
        .clear_i        (load_frame),
        .sample_i       (state_q == ST_SHIFT && SampleEdge),
        .rx_bit_i       (rx_bit),
        .capture_i      (state_q == ST_SHIFT && EndOfFrameDelay),
        .deliver_i      (state_q == ST_DELIVER),
        .frame_len_i    (frame_len),
        .endian_i       (Endian),
        .rx_fifo_full_i (RxFIFOFull),
        .overrun_clear_i(RxOverrunClear),
        .rx_data_o      (RxData),
        .rx_write_o     (RxWrite),
        .overrun_o      (RxOverrun)
    );

    assign SPIOut     = spi_out_q;
    assign TxFIFORead = tx_read_q;

endmodule
